// File: rtl/led_pattern_controller_if.sv
// led_pattern_controller_if: control/status bundle between player core and LED sequencer.
// LED_DIM_EN adds the brightness input.
interface led_pattern_controller_if;
    logic        enable;
    logic [1:0]  mode;
    logic        div_load;
    logic [31:0] div_value;
    logic        flash_req;
    logic        flash_ack;
    logic        step_tick;
    logic        busy;
    logic [7:0]  LED;
`ifdef LED_DIM_EN
    logic [2:0]  brightness;
    modport master (output enable, mode, div_load, div_value, flash_req, brightness,
                    input flash_ack, step_tick, busy, LED);
    modport slave  (input enable, mode, div_load, div_value, flash_req, brightness,
                    output flash_ack, step_tick, busy, LED);
`else
    modport master (output enable, mode, div_load, div_value, flash_req,
                    input flash_ack, step_tick, busy, LED);
    modport slave  (input enable, mode, div_load, div_value, flash_req,
                    output flash_ack, step_tick, busy, LED);
`endif
endinterface

// File: rtl/led_pattern_controller.sv
// led_pattern_controller: prescaled 8-LED pattern sequencer with one-shot flash-all and resume.
// LED_DIM_EN adds a 3-bit PWM brightness control on the LED outputs.
module led_pattern_controller #(
    parameter logic [31:0] STEP_DIV   = 32'd5000000,
    parameter int          HOLD_STEPS = 4
) (
    input logic clk,
    input logic rst,
    led_pattern_controller_if.slave bus
);
    typedef enum logic {RUN, FLASH} state_t;
    state_t      state, state_n;
    logic [31:0] cnt, cnt_n, div_q, div_n, d;
    logic [7:0]  pat, pat_n, pp, hold, hold_n, led_n, init;
    logic [1:0]  mode_q;
    logic        dir, dir_n, pp_dir, running, tc, mode_chg, accept, do_step;
`ifdef LED_DIM_EN
    logic [2:0]  phase;
`endif
    always_comb begin
        d        = (div_q == 32'd0) ? 32'd1 : div_q;
        running  = bus.enable || state == FLASH;
        tc       = running && !bus.div_load && cnt == d - 32'd1;
        mode_chg = bus.mode != mode_q;
        accept   = state == RUN && bus.flash_req;
        do_step  = state == RUN && bus.enable && tc && !mode_chg && !accept;
        init     = bus.mode == 2'b10 ? 8'hFF : bus.mode == 2'b11 ? 8'h00 : 8'h01;
        // ping-pong bounces at the ends; anything not one-hot restarts at bit 0
        pp       = pat == 8'h80 ? 8'h40 : pat == 8'h01 ? 8'h02 :
                   !$onehot(pat) ? 8'h01 : dir ? pat >> 1 : pat << 1;
        pp_dir   = pat == 8'h80 ? 1'b1 : (pat == 8'h01 || !$onehot(pat)) ? 1'b0 : dir;
        cnt_n    = (bus.div_load || mode_chg || accept || tc) ? 32'd0 : running ? cnt + 32'd1 : cnt;
        div_n    = bus.div_load ? bus.div_value : div_q;
        pat_n    = mode_chg ? init : !do_step ? pat :
                   mode_q == 2'b00 ? pp : mode_q == 2'b01 ? {pat[6:0], pat[7]} :
                   mode_q == 2'b10 ? ~pat : 8'h00;
        dir_n    = mode_chg ? 1'b0 : (do_step && mode_q == 2'b00) ? pp_dir : dir;
        state_n  = accept ? FLASH : (state == FLASH && tc && hold == 8'd1) ? RUN : state;
        hold_n   = accept ? 8'(HOLD_STEPS) : (state == FLASH && tc) ? hold - 8'd1 : hold;
        led_n    = state_n == FLASH ? 8'hFF : pat_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= 32'd0;
            div_q         <= STEP_DIV;
            pat           <= 8'h01;
            dir           <= 1'b0;
            mode_q        <= 2'b00;
            hold          <= 8'd0;
            bus.flash_ack <= 1'b0;
            bus.step_tick <= 1'b0;
            bus.busy      <= 1'b0;
            bus.LED       <= 8'h01;
        end else begin
            cnt           <= cnt_n;
            div_q         <= div_n;
            pat           <= pat_n;
            dir           <= dir_n;
            mode_q        <= bus.mode;
            hold          <= hold_n;
            bus.flash_ack <= accept;
            bus.step_tick <= tc;
            bus.busy      <= state_n == FLASH;
`ifdef LED_DIM_EN
            bus.LED       <= led_n & {8{phase < bus.brightness}};
`else
            bus.LED       <= led_n;
`endif
        end
    end
`ifdef LED_DIM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= 3'd0;
        else phase <= phase + 3'd1;
    end
`endif
endmodule

// File: tb/tb_led_pattern_controller.sv
// tb_led_pattern_controller: scoreboard bench; a position-based pattern model predicts every
// registered output cycle by cycle, expectations are queued and popped after each clock edge.
module tb_led_pattern_controller;
    localparam int HOLD = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    led_pattern_controller_if bus ();
    led_pattern_controller #(.STEP_DIV(32'd5), .HOLD_STEPS(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct { logic [7:0] led; logic tick; logic ack; logic busy; } exp_t;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    int          m_cnt, m_idx, m_hold;
    logic [31:0] m_div;
    logic [1:0]  m_mode;
    logic [2:0]  m_ph;
    bit          m_blk, m_fl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_hold = 0; m_div = 32'd5; m_mode = 2'b00;
        m_blk = 1'b1; m_fl = 1'b0; m_ph = 3'd0;
    endtask

    function automatic logic [7:0] pat_val();
        logic [7:0] one = 8'd1;
        case (m_mode)
            2'b00:   return m_idx <= 7 ? one << m_idx : one << (14 - m_idx);
            2'b01:   return one << m_idx;
            2'b10:   return m_blk ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic cyc();
        exp_t e;
        int   d = (m_div == 0) ? 1 : int'(m_div);
        bit   run = bus.enable || m_fl;
        bit   tc = run && !bus.div_load && (m_cnt == d - 1);
        bit   mc = bus.mode != m_mode;
        bit   acc = !m_fl && bus.flash_req;
        e.tick = tc;
        e.ack  = acc;
        if (bus.div_load || mc || acc || tc) m_cnt = 0;
        else if (run) m_cnt++;
        if (bus.div_load) m_div = bus.div_value;
        if (mc) begin
            m_mode = bus.mode; m_idx = 0; m_blk = 1'b1;
        end else if (!m_fl && bus.enable && tc && !acc) begin
            m_idx = (m_idx + 1) % (m_mode == 2'b00 ? 14 : 8);
            m_blk = !m_blk;
        end
        if (acc) begin
            m_fl = 1'b1; m_hold = HOLD;
        end else if (m_fl && tc) begin
            m_hold--;
            if (m_hold == 0) m_fl = 1'b0;
        end
        e.busy = m_fl;
        e.led  = m_fl ? 8'hFF : pat_val();
`ifdef LED_DIM_EN
        if (m_ph >= 3'd7) e.led = 8'h00;
        m_ph++;
`endif
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("led", bus.LED, e.led);
        chk("step_tick", bus.step_tick, e.tick);
        chk("flash_ack", bus.flash_ack, e.ack);
        chk("busy", bus.busy, e.busy);
        bus.div_load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load(input logic [31:0] v);
        bus.div_load = 1'b1; bus.div_value = v;
        cyc();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_led", bus.LED, 8'h01);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ack", bus.flash_ack, 1'b0);
        chk("rst_tick", bus.step_tick, 1'b0);
        bus.flash_req = 1'b0; bus.mode = 2'b00; bus.enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.enable = 1'b1; bus.mode = 2'b00; bus.div_load = 1'b0;
        bus.div_value = 32'd0; bus.flash_req = 1'b0;
`ifdef LED_DIM_EN
        bus.brightness = 3'd7;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_led", bus.LED, 8'h01);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_ack", bus.flash_ack, 1'b0);
        chk("reset_tick", bus.step_tick, 1'b0);
        rst = 1'b0;
        run(12);
        load(32'd3);
        run(50);
        bus.mode = 2'b01;
        load(32'd1);
        run(18);
        bus.mode = 2'b10;
        run(8);
        bus.mode = 2'b00;
        load(32'd2);
        run(12);
        bus.flash_req = 1'b1; cyc(); bus.flash_req = 1'b0;
        run(16);
        bus.flash_req = 1'b1;
        run(30);
        bus.flash_req = 1'b0;
        run(6);
        bus.enable = 1'b0;
        run(20);
        load(32'd0);
        bus.enable = 1'b1;
        run(20);
        load(32'd3);
        bus.flash_req = 1'b1; cyc(); bus.flash_req = 1'b0;
        run(3);
        bus.mode = 2'b01;
        run(14);
        bus.mode = 2'b00;
        run(20);
        for (int i = 0; i < 400; i++) begin
            bus.enable    = $urandom_range(0, 9) != 0;
            bus.flash_req = $urandom_range(0, 24) == 0;
            if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) begin
                bus.div_load = 1'b1; bus.div_value = $urandom_range(0, 4);
            end
            cyc();
        end
        bus.enable = 1'b1; bus.flash_req = 1'b0; bus.mode = 2'b00;
        load(32'd2);
        run(6);
        bus.flash_req = 1'b1; cyc(); bus.flash_req = 1'b0;
        run(2);
        async_reset();
        run(10);
        load(32'd4);
        run(2);
        async_reset();
        run(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/led_pattern_controller.md
Name: led_pattern_controller

Overview:
Sequences the 8-LED status bank for the music player.
- Generates the step rate from a programmable prescaler.
- Runs one of four display patterns (ping-pong, wrap chase, blink, off).
- Grants one-shot "flash all" requests from the player core, then resumes the interrupted pattern exactly where it stopped.
- Sits between the player control logic and the board LED pins.

Parameters:
STEP_DIV, 5000000, reset value of the prescaler divide register (clk cycles per pattern step)
HOLD_STEPS, 4, number of step ticks the LEDs stay at 8'hFF during a flash (valid range 1..255)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = pattern advances on step ticks; 0 = pattern frozen
mode  input  2  00 ping-pong, 01 chase-left-wrap, 10 blink, 11 off
div_load  input  1  1-cycle strobe; loads div_value into the divide register
div_value  input  32  new cycles-per-step; 0 is treated as 1
flash_req  input  1  level request for a flash
flash_ack  output  1  1-cycle pulse when a flash is accepted
step_tick  output  1  1-cycle pulse on each prescaler terminal count
busy  output  1  1 while in FLASH state
LED  output  8  LED drive

Behaviour:
- Reset (asynchronous) clears or sets everything to:
  - prescaler count = 0, div register = STEP_DIV, pattern = 8'h01, direction = left
  - mode_q = 2'b00, state = RUN, hold counter = 0
  - flash_ack = 0, step_tick = 0, busy = 0, LED = 8'h01
  - Reset asserted mid-flash abandons the flash; there is no resume.
- Prescaler:
  - Counts 0..D-1, where D = max(div register, 1).
  - step_tick = 1 on the cycle the count equals D-1; the count then wraps to 0.
  - The prescaler runs when enable=1 or state=FLASH; otherwise it holds its value.
  - div_load: div register <= div_value and count <= 0. No step_tick is produced on the load cycle.
- Mode change:
  - mode is compared against mode_q every cycle.
  - On a mismatch: mode_q <= mode, pattern <= initial value of the new mode, direction <= left, count <= 0.
  - This applies even when enable=0.
  - Initial values: ping-pong 8'h01, chase 8'h01, blink 8'hFF, off 8'h00.
  - In FLASH state, a mode change is applied to the saved pattern; the LEDs stay at 8'hFF until the flash ends.
- Pattern step (RUN state, enable=1, step_tick):
  - Ping-pong: one-hot shift in the current direction. At 8'h80 the next value is 8'h40 and direction becomes right; at 8'h01 the next value is 8'h02 and direction becomes left. The period is 14 steps. A non-one-hot value (unreachable) recovers to 8'h01.
  - Chase: left rotate; 8'h80 -> 8'h01.
  - Blink: pattern <= ~pattern (8'hFF <-> 8'h00).
  - Off: pattern stays 8'h00.
- State machine (RUN, FLASH):
  - RUN -> FLASH when flash_req=1:
    - flash_ack = 1 for that one cycle; hold counter <= HOLD_STEPS; count <= 0.
    - The pattern register and direction are frozen.
  - FLASH:
    - LED = 8'hFF, busy = 1.
    - Each step_tick decrements the hold counter.
    - On the step_tick that takes the counter to 0, return to RUN. LED shows the frozen pattern from the next cycle.
    - flash_req in FLASH is ignored: no ack, no extension.
    - flash_req still high on the first RUN cycle is accepted again, giving a back-to-back flash.
- Simultaneous events:
  - div_load and a step_tick in the same cycle: the load wins and no tick occurs.
  - A mode change and a step_tick in the same cycle: the mode change wins and no pattern step occurs.
- Output timing:
  - All outputs are registered.
  - LED reflects the pattern from the cycle after its update.

Optional Feature:
LED_DIM_EN
- Defined:
  - Adds the port brightness, input, 3 bits.
  - A free-running 3-bit PWM phase counter increments every clk and is reset to 0.
  - LED = pattern_or_flash & {8{phase < brightness}}, registered.
  - brightness=0 gives all LEDs off; brightness=7 gives a 7/8 duty cycle.
- Not defined:
  - The port and the phase counter are absent.
  - LED = pattern_or_flash, full duty cycle.

Test Plan:
1. Reset, then mode=00, enable=1, div_load with div_value=3 -> step_tick every 3 cycles; LED sequence 01,02,04,...,80,40,...,01,02; period 14 ticks; first tick 3 cycles after load.
2. mode=01, div=1 -> LED 01,02,...,80,01 on consecutive cycles; then mode=10 -> LED=FF, then 00/FF alternating every cycle.
3. Ping-pong with LED=08 moving right, div=2: pulse flash_req -> flash_ack for 1 cycle, busy=1, LED=FF for HOLD_STEPS=4 ticks (8 cycles), then LED=08 and the next step gives 04.
4. Hold flash_req high throughout a flash -> exactly one ack per flash; a second ack on the first RUN cycle after the flash; no ack while busy=1.
5. enable=0 mid-pattern for 20 cycles -> LED and prescaler frozen; div_value=0 load then enable=1 -> pattern advances every cycle.
6. Assert rst during a flash and during a prescaler count -> LED=01, busy=0, flash_ack=0 immediately (asynchronous); ping-pong restarts from 01 after release.
